tri_assembler: RTL and testbench
================================

Name: tri_assembler

Overview:
- Downstream consumer of the projection stage.
- Accepts projected screen-space vertices (9-bit x, y, z) one at a time and groups every three into a triangle.
- Computes the signed doubled area and the bounding box, culls back-facing or degenerate triangles, and presents surviving triangles to the rasteriser with a valid/ready handshake.
- Tracks object boundaries from the upstream obj_done signal.

Parameters:
- CULL_BACK, 1: when 1, drop triangles with area < 0 (clockwise in screen space).
- CULL_ZERO, 1: when 1, drop triangles with area == 0.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous reset, active-low.
- coor_in  in  9 x [2:0]  vertex; [2]=x, [1]=y, [0]=z, unsigned.
- valid_in  in  1  one-cycle strobe; vertex is accepted when valid_in=1 and ready_out=1.
- obj_done_in  in  1  level from upstream; a rising edge marks end of object.
- ready_out  out  1  block can accept a vertex this cycle.
- tri_x_out, tri_y_out, tri_z_out  out  9 x [2:0]  triangle vertices; index = arrival order.
- bbox_min_out, bbox_max_out  out  9 x [1:0]  [1]=x, [0]=y.
- area_out  out  21 signed  doubled signed area.
- valid_out  out  1  triangle present; held until accepted.
- ready_in  in  1  rasteriser accepts when valid_out=1 and ready_in=1.
- obj_done_out  out  1  one-cycle pulse at end of object.
- cull_cnt_out  out  16  count of culled triangles, saturating.
- drop_cnt_out  out  8  count of partial triangles discarded, saturating.

Behaviour:
- Reset (rst_in=0 at a clock edge): all of the following are 0: state=COLLECT, vcnt, ready_out, valid_out, obj_done_out, cull_cnt_out, drop_cnt_out, all data outputs, and the obj_done edge register. ready_out rises the cycle after reset release.
- Reset mid-operation discards any held vertices or pending triangle with no output pulse.
- COLLECT:
  - ready_out=1.
  - On accept, store the vertex in slot vcnt and increment vcnt.
  - On accept with vcnt==2: go to CALC, ready_out=0 from the next cycle.
- CALC (exactly 1 cycle):
  - dx1=x1-x0, dy1=y1-y0, dx2=x2-x0, dy2=y2-y0; all 10-bit signed.
  - area = dx1*dy2 - dx2*dy1; products 20-bit signed, result 21-bit signed, no truncation.
  - bbox min/max computed per axis over the three vertices.
  - Cull if (CULL_BACK && area<0) or (CULL_ZERO && area==0): increment cull_cnt, vcnt=0, return to COLLECT.
  - Otherwise register all outputs, valid_out=1, go to HOLD.
- HOLD:
  - Outputs stable; valid_out stays 1 until ready_in=1, then valid_out=0.
  - Once ready_in=1: vcnt=0, return to COLLECT.
  - ready_out=0 throughout HOLD.
- Latency: third vertex accept at cycle T gives valid_out=1 at T+2. Best-case throughput is one triangle per 5 cycles.
- obj_done handling:
  - Edge detect: done_edge = obj_done_in & ~obj_done_d.
  - The edge is latched into a done_pend flag in any state.
  - done_pend is serviced only in COLLECT with no valid_in that cycle:
    - if vcnt!=0: discard the partial triangle, increment drop_cnt, vcnt=0;
    - pulse obj_done_out for 1 cycle;
    - clear done_pend.
  - valid_in in the same cycle as done_edge: the vertex is accepted first and done is serviced on a later cycle. obj_done_out therefore never precedes the last triangle of the object.
- valid_in while ready_out=0 is ignored (upstream contract forbids it; assertion in bench).
- Counters saturate at all-ones and never wrap.

Decomposition:
- Package tri_pkg:
  - vertex_t struct {x,y,z: logic[8:0]};
  - COORD_W=9, AREA_W=21;
  - state enum {COLLECT, CALC, HOLD}.
- Sub-module tri_area: combinational area and bbox from three vertex_t. Instantiated once and registered in CALC.

Test Plan:
- Front-facing triangle: vertices (10,10,5), (20,10,5), (10,30,5) with ready_in=1 -> valid_out 2 cycles after third accept; area_out=200; bbox_min=(10,10), bbox_max=(20,30); cull_cnt=0.
- Back-facing triangle: same vertices in order v0,v2,v1 with CULL_BACK=1 -> no valid_out, cull_cnt=1. With CULL_BACK=0 -> emitted with area_out=-200.
- Degenerate and extreme: collinear (0,0,0), (5,5,0), (10,10,0) -> culled, cull_cnt=1. Extremes (0,0), (511,0), (0,511) -> area_out=261121, no overflow.
- Backpressure: hold ready_in=0 for 20 cycles during HOLD -> outputs stable, ready_out=0, extra valid_in ignored. ready_in=1 -> one handshake, then ready_out=1.
- Object boundary: 4 vertices then obj_done_in rising edge -> one triangle emitted, then drop_cnt=1 and a single-cycle obj_done_out after the handshake. Done edge coincident with the 3rd vertex -> triangle emitted before obj_done_out.
- Reset in HOLD (rst_in=0 for 1 cycle) -> valid_out=0 and counters=0 next cycle. A fresh 3 vertices produce a correct triangle.

Source files
------------

// File: rtl/tri_assembler_pkg.sv
// Shared types and helpers for the triangle assembler: vertex record, FSM states
// and the three-way min/max used by the bounding box.
package tri_pkg;

    localparam int COORD_W = 9;
    localparam int AREA_W  = 21;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } vertex_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CALC    = 2'd1,
        HOLD    = 2'd2
    } state_t;

    function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tri_assembler_area.sv
// Combinational doubled signed area and per-axis bounding box of three vertices.
// Positive area means counter-clockwise (front-facing) in screen space.
module tri_area
    import tri_pkg::*;
(
    input  vertex_t                    v0,
    input  vertex_t                    v1,
    input  vertex_t                    v2,
    output logic signed [AREA_W-1:0]   area,
    output logic [1:0][COORD_W-1:0]    bbox_min,
    output logic [1:0][COORD_W-1:0]    bbox_max
);

    logic signed [COORD_W:0]     dx1_s, dy1_s, dx2_s, dy2_s;
    logic signed [2*COORD_W+1:0] p1_s, p2_s;

    assign dx1_s = $signed({1'b0, v1.x}) - $signed({1'b0, v0.x});
    assign dy1_s = $signed({1'b0, v1.y}) - $signed({1'b0, v0.y});
    assign dx2_s = $signed({1'b0, v2.x}) - $signed({1'b0, v0.x});
    assign dy2_s = $signed({1'b0, v2.y}) - $signed({1'b0, v0.y});

    assign p1_s = dx1_s * dy2_s;
    assign p2_s = dx2_s * dy1_s;

    // Sign-extend both products one bit so the difference can never overflow.
    assign area = $signed({p1_s[2*COORD_W+1], p1_s} - {p2_s[2*COORD_W+1], p2_s});

    assign bbox_min[1] = min3(v0.x, v1.x, v2.x);
    assign bbox_min[0] = min3(v0.y, v1.y, v2.y);
    assign bbox_max[1] = max3(v0.x, v1.x, v2.x);
    assign bbox_max[0] = max3(v0.y, v1.y, v2.y);

endmodule

// File: rtl/tri_assembler.sv
// Groups projected vertices into triangles, culls back-facing/degenerate ones and
// hands survivors to the rasteriser; also forwards end-of-object markers in order.
module tri_assembler
    import tri_pkg::*;
#(
    parameter bit CULL_BACK = 1'b1,
    parameter bit CULL_ZERO = 1'b1
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [2:0][COORD_W-1:0]     coor_in,
    input  logic                        valid_in,
    input  logic                        obj_done_in,
    output logic                        ready_out,
    output logic [2:0][COORD_W-1:0]     tri_x_out,
    output logic [2:0][COORD_W-1:0]     tri_y_out,
    output logic [2:0][COORD_W-1:0]     tri_z_out,
    output logic [1:0][COORD_W-1:0]     bbox_min_out,
    output logic [1:0][COORD_W-1:0]     bbox_max_out,
    output logic signed [AREA_W-1:0]    area_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic                        obj_done_out,
    output logic [15:0]                 cull_cnt_out,
    output logic [7:0]                  drop_cnt_out
);

    state_t                     state_r, next_state_s;
    logic [1:0]                 vcnt_r;
    vertex_t                    v0_r, v1_r, v2_r;
    vertex_t                    in_vert_s;
    logic                       obj_done_d_r, done_pend_r;
    logic                       done_edge_s;
    logic                       accept_s, service_s, cull_s, emit_s, handshake_s;
    logic signed [AREA_W-1:0]   area_s;
    logic [1:0][COORD_W-1:0]    bmin_s, bmax_s;

    assign in_vert_s   = vertex_t'(coor_in);
    assign done_edge_s = obj_done_in & ~obj_done_d_r;

    tri_area u_area (
        .v0       (v0_r),
        .v1       (v1_r),
        .v2       (v2_r),
        .area     (area_s),
        .bbox_min (bmin_s),
        .bbox_max (bmax_s)
    );

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r <= COLLECT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        service_s    = 1'b0;
        cull_s       = 1'b0;
        emit_s       = 1'b0;
        handshake_s  = 1'b0;
        case (state_r)
            COLLECT: begin
                accept_s  = valid_in & ready_out;
                // A pending end-of-object waits for an idle input cycle so it never overtakes a vertex.
                service_s = done_pend_r & ~valid_in;
                if (accept_s && (vcnt_r == 2'd2)) begin
                    next_state_s = CALC;
                end else begin
                    next_state_s = COLLECT;
                end
            end
            CALC: begin
                cull_s = ((CULL_BACK == 1'b1) && (area_s < 21'sd0)) ||
                         ((CULL_ZERO == 1'b1) && (area_s == 21'sd0));
                emit_s = ~cull_s;
                if (cull_s) begin
                    next_state_s = COLLECT;
                end else begin
                    next_state_s = HOLD;
                end
            end
            HOLD: begin
                handshake_s = ready_in;
                if (ready_in) begin
                    next_state_s = COLLECT;
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: begin
                next_state_s = COLLECT;
            end
        endcase
    end

    // Vertex slots, vertex count, done tracking and handshake flags
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            v0_r         <= '0;
            v1_r         <= '0;
            v2_r         <= '0;
            vcnt_r       <= 2'd0;
            obj_done_d_r <= 1'b0;
            done_pend_r  <= 1'b0;
            ready_out    <= 1'b0;
            obj_done_out <= 1'b0;
        end else begin
            obj_done_d_r <= obj_done_in;
            done_pend_r  <= (done_pend_r & ~service_s) | done_edge_s;
            ready_out    <= (next_state_s == COLLECT);
            obj_done_out <= service_s;
            if (accept_s) begin
                case (vcnt_r)
                    2'd0:    v0_r <= in_vert_s;
                    2'd1:    v1_r <= in_vert_s;
                    2'd2:    v2_r <= in_vert_s;
                    default: v0_r <= v0_r;
                endcase
                vcnt_r <= vcnt_r + 2'd1;
            end else if (service_s || cull_s || handshake_s) begin
                vcnt_r <= 2'd0;
            end else begin
                vcnt_r <= vcnt_r;
            end
        end
    end

    // Registered triangle outputs and saturating event counters
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            tri_x_out    <= '0;
            tri_y_out    <= '0;
            tri_z_out    <= '0;
            bbox_min_out <= '0;
            bbox_max_out <= '0;
            area_out     <= '0;
            valid_out    <= 1'b0;
            cull_cnt_out <= 16'd0;
            drop_cnt_out <= 8'd0;
        end else begin
            if (emit_s) begin
                tri_x_out    <= {v2_r.x, v1_r.x, v0_r.x};
                tri_y_out    <= {v2_r.y, v1_r.y, v0_r.y};
                tri_z_out    <= {v2_r.z, v1_r.z, v0_r.z};
                bbox_min_out <= bmin_s;
                bbox_max_out <= bmax_s;
                area_out     <= area_s;
                valid_out    <= 1'b1;
            end else if (handshake_s) begin
                valid_out    <= 1'b0;
            end else begin
                valid_out    <= valid_out;
            end
            if (cull_s && (cull_cnt_out != 16'hFFFF)) begin
                cull_cnt_out <= cull_cnt_out + 16'd1;
            end else begin
                cull_cnt_out <= cull_cnt_out;
            end
            if (service_s && (vcnt_r != 2'd0) && (drop_cnt_out != 8'hFF)) begin
                drop_cnt_out <= drop_cnt_out + 8'd1;
            end else begin
                drop_cnt_out <= drop_cnt_out;
            end
        end
    end

endmodule

// File: tb/tb_tri_assembler.sv
// Directed bench for tri_assembler: a triangle vector table plus hand-built
// sequences for backpressure, object boundaries, reset in HOLD and saturation.
module tb_tri_assembler;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic [2:0][8:0]   coor_in = '0;
    logic              valid_in = 1'b0;
    logic              obj_done_in = 1'b0;
    logic              ready_in = 1'b1;

    logic              ready_out, valid_out, obj_done_out;
    logic [2:0][8:0]   tri_x_out, tri_y_out, tri_z_out;
    logic [1:0][8:0]   bbox_min_out, bbox_max_out;
    logic signed [20:0] area_out;
    logic [15:0]       cull_cnt_out;
    logic [7:0]        drop_cnt_out;

    logic              ready_b, valid_b, obj_done_b;
    logic [2:0][8:0]   tri_x_b, tri_y_b, tri_z_b;
    logic [1:0][8:0]   bbox_min_b, bbox_max_b;
    logic signed [20:0] area_b;
    logic [15:0]       cull_cnt_b;
    logic [7:0]        drop_cnt_b;

    int checks = 0;
    int errors = 0;
    int exp_cull = 0;

    always #5 clk_in = ~clk_in;

    tri_assembler dut (
        .clk_in(clk_in), .rst_in(rst_in), .coor_in(coor_in), .valid_in(valid_in),
        .obj_done_in(obj_done_in), .ready_out(ready_out), .tri_x_out(tri_x_out),
        .tri_y_out(tri_y_out), .tri_z_out(tri_z_out), .bbox_min_out(bbox_min_out),
        .bbox_max_out(bbox_max_out), .area_out(area_out), .valid_out(valid_out),
        .ready_in(ready_in), .obj_done_out(obj_done_out), .cull_cnt_out(cull_cnt_out),
        .drop_cnt_out(drop_cnt_out)
    );

    tri_assembler #(.CULL_BACK(1'b0), .CULL_ZERO(1'b1)) dut_b (
        .clk_in(clk_in), .rst_in(rst_in), .coor_in(coor_in), .valid_in(valid_in),
        .obj_done_in(obj_done_in), .ready_out(ready_b), .tri_x_out(tri_x_b),
        .tri_y_out(tri_y_b), .tri_z_out(tri_z_b), .bbox_min_out(bbox_min_b),
        .bbox_max_out(bbox_max_b), .area_out(area_b), .valid_out(valid_b),
        .ready_in(ready_in), .obj_done_out(obj_done_b), .cull_cnt_out(cull_cnt_b),
        .drop_cnt_out(drop_cnt_b)
    );

    typedef struct {
        logic [2:0][8:0]    c0, c1, c2;
        logic               emit, emit_b;
        logic signed [20:0] area;
        logic [1:0][8:0]    bmin, bmax;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Feeds three back-to-back vertices and checks the CALC/HOLD timeline.
    task automatic run_vec(input vec_t r, input string tag);
        chk({tag, "_rdy_pre"}, ready_out, 1);
        @(negedge clk_in); coor_in = r.c0; valid_in = 1'b1;
        @(negedge clk_in); coor_in = r.c1;
        @(negedge clk_in); coor_in = r.c2;
        @(negedge clk_in); valid_in = 1'b0;
        chk({tag, "_rdy_calc"}, ready_out, 0);
        chk({tag, "_vld_calc"}, valid_out, 0);
        @(negedge clk_in);
        if (!r.emit) exp_cull++;
        chk({tag, "_vld"}, valid_out, r.emit);
        chk({tag, "_cull"}, cull_cnt_out, exp_cull);
        if (r.emit) begin
            chk({tag, "_area"}, area_out, r.area);
            chk({tag, "_bmin"}, bbox_min_out, r.bmin);
            chk({tag, "_bmax"}, bbox_max_out, r.bmax);
            chk({tag, "_x"}, tri_x_out, {r.c2[2], r.c1[2], r.c0[2]});
            chk({tag, "_y"}, tri_y_out, {r.c2[1], r.c1[1], r.c0[1]});
            chk({tag, "_z"}, tri_z_out, {r.c2[0], r.c1[0], r.c0[0]});
        end
        chk({tag, "_vld_b"}, valid_b, r.emit_b);
        if (r.emit_b) chk({tag, "_area_b"}, area_b, r.area);
        if (ready_in) begin
            @(negedge clk_in);
            chk({tag, "_vld_post"}, valid_out, 0);
            chk({tag, "_rdy_post"}, ready_out, 1);
        end
    endtask

    initial begin
        int bad;
        int pulses;
        int first;

        vecs[0] = '{c0: {9'd10, 9'd10, 9'd5}, c1: {9'd20, 9'd10, 9'd5}, c2: {9'd10, 9'd30, 9'd5},
                    emit: 1'b1, emit_b: 1'b1, area: 21'sd200, bmin: {9'd10, 9'd10}, bmax: {9'd20, 9'd30}};
        vecs[1] = '{c0: {9'd10, 9'd10, 9'd5}, c1: {9'd10, 9'd30, 9'd5}, c2: {9'd20, 9'd10, 9'd5},
                    emit: 1'b0, emit_b: 1'b1, area: -21'sd200, bmin: {9'd10, 9'd10}, bmax: {9'd20, 9'd30}};
        vecs[2] = '{c0: {9'd0, 9'd0, 9'd0}, c1: {9'd5, 9'd5, 9'd0}, c2: {9'd10, 9'd10, 9'd0},
                    emit: 1'b0, emit_b: 1'b0, area: 21'sd0, bmin: {9'd0, 9'd0}, bmax: {9'd10, 9'd10}};
        vecs[3] = '{c0: {9'd0, 9'd0, 9'd0}, c1: {9'd511, 9'd0, 9'd0}, c2: {9'd0, 9'd511, 9'd0},
                    emit: 1'b1, emit_b: 1'b1, area: 21'sd261121, bmin: {9'd0, 9'd0}, bmax: {9'd511, 9'd511}};
        vecs[4] = '{c0: {9'd100, 9'd50, 9'd7}, c1: {9'd300, 9'd400, 9'd1}, c2: {9'd30, 9'd200, 9'd9},
                    emit: 1'b1, emit_b: 1'b1, area: 21'sd54500, bmin: {9'd30, 9'd50}, bmax: {9'd300, 9'd400}};
        vecs[5] = '{c0: {9'd511, 9'd511, 9'd3}, c1: {9'd0, 9'd511, 9'd3}, c2: {9'd511, 9'd0, 9'd3},
                    emit: 1'b1, emit_b: 1'b1, area: 21'sd261121, bmin: {9'd0, 9'd0}, bmax: {9'd511, 9'd511}};

        // Reset state
        @(posedge clk_in); @(posedge clk_in); @(negedge clk_in);
        chk("rst_rdy", ready_out, 0);
        chk("rst_vld", valid_out, 0);
        chk("rst_area", area_out, 0);
        chk("rst_cull", cull_cnt_out, 0);
        chk("rst_drop", drop_cnt_out, 0);
        chk("rst_done", obj_done_out, 0);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("rdy_after_rst", ready_out, 1);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: hold 20 cycles with stray vertices offered
        ready_in = 1'b0;
        run_vec(vecs[0], "bp");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            valid_in = i[0];
            coor_in = {9'd400, 9'd400, 9'd400};
            if (!(valid_out && !ready_out && area_out == 21'sd200 && bbox_max_out == {9'd20, 9'd30}))
                bad++;
        end
        chk("bp_stable", bad, 0);
        @(negedge clk_in); valid_in = 1'b0; ready_in = 1'b1;
        @(negedge clk_in);
        chk("bp_vld_released", valid_out, 0);
        chk("bp_rdy_released", ready_out, 1);

        // Object boundary: full triangle plus one stray vertex, then done edge
        run_vec(vecs[4], "obj");
        @(negedge clk_in); coor_in = {9'd1, 9'd2, 9'd3}; valid_in = 1'b1;
        @(negedge clk_in); valid_in = 1'b0; obj_done_in = 1'b1;
        pulses = 0; first = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_in);
            if (obj_done_out) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        chk("obj_pulses", pulses, 1);
        chk("obj_first", first, 2);
        chk("obj_drop", drop_cnt_out, 1);
        obj_done_in = 1'b0;
        @(negedge clk_in);

        // Done edge coincident with the third vertex
        coor_in = vecs[0].c0; valid_in = 1'b1;
        @(negedge clk_in); coor_in = vecs[0].c1;
        @(negedge clk_in); coor_in = vecs[0].c2; obj_done_in = 1'b1;
        @(negedge clk_in); valid_in = 1'b0;
        chk("coin_done_e3", obj_done_out, 0);
        @(negedge clk_in);
        chk("coin_vld_e4", valid_out, 1);
        chk("coin_done_e4", obj_done_out, 0);
        @(negedge clk_in);
        chk("coin_vld_e5", valid_out, 0);
        chk("coin_done_e5", obj_done_out, 0);
        @(negedge clk_in);
        chk("coin_done_e6", obj_done_out, 1);
        chk("coin_drop", drop_cnt_out, 1);
        @(negedge clk_in);
        chk("coin_done_e7", obj_done_out, 0);
        obj_done_in = 1'b0;

        // Reset while holding a triangle
        ready_in = 1'b0;
        run_vec(vecs[3], "rsthold");
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        exp_cull = 0;
        chk("rh_vld", valid_out, 0);
        chk("rh_rdy", ready_out, 0);
        chk("rh_cull", cull_cnt_out, 0);
        chk("rh_drop", drop_cnt_out, 0);
        chk("rh_area", area_out, 0);
        ready_in = 1'b1;
        @(negedge clk_in);
        run_vec(vecs[5], "post_rst");

        // Drop counter saturation: 260 single-vertex objects
        for (int i = 0; i < 260; i++) begin
            @(negedge clk_in); coor_in = {9'd7, 9'd7, 9'd7}; valid_in = 1'b1;
            @(negedge clk_in); valid_in = 1'b0; obj_done_in = 1'b1;
            @(negedge clk_in); obj_done_in = 1'b0;
        end
        @(negedge clk_in);
        @(negedge clk_in);
        chk("drop_sat", drop_cnt_out, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
